// File: rtl/fetch_stage.sv
// LEGv8 instruction fetch stage: program counter, instruction-memory addressing
// and the IF/ID pipeline register, with stall, flush, redirect and a delivered-instruction count.
module fetch_stage #(
    parameter int              N        = 64,
    parameter int              ADDR_W   = 6,
    parameter logic [N-1:0]    RESET_PC = 64'h0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_F,
    input  logic              flush_D,
    input  logic              PCSrc_D,
    input  logic [N-1:0]      PCBranch_D,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_q,
    output logic [31:0]       instr_D,
    output logic [N-1:0]      pc_D,
    output logic              valid_D,
    output logic [31:0]       fetch_count
);

    logic [N-1:0] pc_p0;
    logic [N-1:0] pc_plus4_p0;
    logic [N-1:0] branch_tgt_p0;
    logic         squash_p0;
    logic         load_p0;

    function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
        return (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
    endfunction

    // ---- IF: PC register and instruction-memory address ----
    assign pc_plus4_p0   = pc_p0 + N'(4);
    assign branch_tgt_p0 = {PCBranch_D[N-1:2], 2'b00};
    assign imem_addr     = pc_p0[ADDR_W+1:2];

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_p0 <= RESET_PC;
        end else if (PCSrc_D) begin
            pc_p0 <= branch_tgt_p0;
        end else if (!stall_F) begin
            pc_p0 <= pc_plus4_p0;
        end
    end

    // ---- IF/ID boundary: redirect squashes the wrong-path fetch even when stalled ----
    assign squash_p0 = flush_D || PCSrc_D;
    assign load_p0   = !squash_p0 && !stall_F;

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_D     <= 32'd0;
            pc_D        <= '0;
            valid_D     <= 1'b0;
            fetch_count <= 32'd0;
        end else if (squash_p0) begin
            instr_D     <= 32'd0;
            pc_D        <= '0;
            valid_D     <= 1'b0;
        end else if (load_p0) begin
            instr_D     <= imem_q;
            pc_D        <= pc_p0;
            valid_D     <= 1'b1;
            fetch_count <= sat_inc(fetch_count);
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage: reset, free-run, redirect, stall, flush,
// address aliasing, mid-run reset and PC wrap (second instance with a high RESET_PC).
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_F;
    logic        flush_D;
    logic        PCSrc_D;
    logic [63:0] PCBranch_D;
    logic [5:0]  imem_addr;
    logic [31:0] imem_q;
    logic [31:0] instr_D;
    logic [63:0] pc_D;
    logic        valid_D;
    logic [31:0] fetch_count;

    logic        reset2;
    logic [5:0]  imem_addr2;
    logic [31:0] imem_q2;
    logic [31:0] instr_D2;
    logic [63:0] pc_D2;
    logic        valid_D2;
    logic [31:0] fetch_count2;

    int vectors    = 0;
    int miscompares = 0;
    logic [134:0] got, exp;

    always #5 clk = ~clk;

    assign imem_q  = 32'hF840_0000 + {26'd0, imem_addr};
    assign imem_q2 = 32'hF840_0000 + {26'd0, imem_addr2};

    fetch_stage #(.N(64), .ADDR_W(6), .RESET_PC(64'h0)) dut (
        .clk(clk), .reset(reset), .stall_F(stall_F), .flush_D(flush_D),
        .PCSrc_D(PCSrc_D), .PCBranch_D(PCBranch_D), .imem_addr(imem_addr),
        .imem_q(imem_q), .instr_D(instr_D), .pc_D(pc_D), .valid_D(valid_D),
        .fetch_count(fetch_count)
    );

    fetch_stage #(.N(64), .ADDR_W(6), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(reset2), .stall_F(1'b0), .flush_D(1'b0),
        .PCSrc_D(1'b0), .PCBranch_D(64'h0), .imem_addr(imem_addr2),
        .imem_q(imem_q2), .instr_D(instr_D2), .pc_D(pc_D2), .valid_D(valid_D2),
        .fetch_count(fetch_count2)
    );

    function automatic logic [31:0] word(input int k);
        return 32'hF840_0000 + 32'(k);
    endfunction

    function automatic logic [134:0] pack(input logic v, input logic [63:0] pc,
                                          input logic [31:0] ins, input logic [31:0] cnt,
                                          input logic [5:0] addr);
        return {v, pc, ins, cnt, addr};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; stall_F = 1'b0; flush_D = 1'b0; PCSrc_D = 1'b0; PCBranch_D = 64'h0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset2 = 1'b1;
        do_reset();
        got = pack(valid_D, pc_D, instr_D, fetch_count, imem_addr);
        exp = pack(1'b0, 64'h0, 32'h0, 32'd0, 6'd0);
        vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL reset got=%h exp=%h", got, exp); end
        got = pack(valid_D2, pc_D2, instr_D2, fetch_count2, imem_addr2);
        exp = pack(1'b0, 64'h0, 32'h0, 32'd0, 6'd63);
        vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL reset_wrap_inst got=%h exp=%h", got, exp); end
    endtask

    task automatic test_free_run();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            tick();
            got = pack(valid_D, pc_D, instr_D, fetch_count, imem_addr);
            exp = pack(1'b1, 64'(4 * k), word(k), 32'(k + 1), 6'(k + 1));
            vectors++;
            if (got !== exp) begin miscompares++; $display("FAIL free_run[%0d] got=%h exp=%h", k, got, exp); end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        tick(); tick();
        PCSrc_D = 1'b1; PCBranch_D = 64'h23;
        tick();
        got = pack(valid_D, pc_D, instr_D, fetch_count, imem_addr);
        exp = pack(1'b0, 64'h0, 32'h0, 32'd2, 6'd8);
        vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL redirect_bubble got=%h exp=%h", got, exp); end
        PCSrc_D = 1'b0; PCBranch_D = 64'h0;
        tick();
        got = pack(valid_D, pc_D, instr_D, fetch_count, imem_addr);
        exp = pack(1'b1, 64'h20, word(8), 32'd3, 6'd9);
        vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL redirect_target got=%h exp=%h", got, exp); end
    endtask

    task automatic test_stall();
        do_reset();
        tick(); tick();
        stall_F = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            got = pack(valid_D, pc_D, instr_D, fetch_count, imem_addr);
            exp = pack(1'b1, 64'h4, word(1), 32'd2, 6'd2);
            vectors++;
            if (got !== exp) begin miscompares++; $display("FAIL stall_hold[%0d] got=%h exp=%h", k, got, exp); end
        end
        stall_F = 1'b0;
        tick();
        got = pack(valid_D, pc_D, instr_D, fetch_count, imem_addr);
        exp = pack(1'b1, 64'h8, word(2), 32'd3, 6'd3);
        vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL stall_release got=%h exp=%h", got, exp); end
    endtask

    task automatic test_stall_flush();
        do_reset();
        tick(); tick(); tick();
        stall_F = 1'b1; flush_D = 1'b1;
        tick();
        got = pack(valid_D, pc_D, instr_D, fetch_count, imem_addr);
        exp = pack(1'b0, 64'h0, 32'h0, 32'd3, 6'd3);
        vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL stall_flush got=%h exp=%h", got, exp); end
        stall_F = 1'b0; flush_D = 1'b0;
        tick();
        got = pack(valid_D, pc_D, instr_D, fetch_count, imem_addr);
        exp = pack(1'b1, 64'hC, word(3), 32'd4, 6'd4);
        vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL stall_flush_release got=%h exp=%h", got, exp); end
    endtask

    task automatic test_redirect_over_stall();
        // continues from PC=16, fetch_count=4
        stall_F = 1'b1; PCSrc_D = 1'b1; PCBranch_D = 64'h1_0000_0107;
        tick();
        got = pack(valid_D, pc_D, instr_D, fetch_count, imem_addr);
        exp = pack(1'b0, 64'h0, 32'h0, 32'd4, 6'd1);
        vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL redirect_stall got=%h exp=%h", got, exp); end
        stall_F = 1'b0; PCSrc_D = 1'b0; PCBranch_D = 64'h0;
        tick();
        got = pack(valid_D, pc_D, instr_D, fetch_count, imem_addr);
        exp = pack(1'b1, 64'h1_0000_0104, word(1), 32'd5, 6'd2);
        vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL redirect_alias got=%h exp=%h", got, exp); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        tick(); tick(); tick();
        reset = 1'b1; stall_F = 1'b1; flush_D = 1'b1; PCSrc_D = 1'b1; PCBranch_D = 64'h80;
        tick();
        got = pack(valid_D, pc_D, instr_D, fetch_count, imem_addr);
        exp = pack(1'b0, 64'h0, 32'h0, 32'd0, 6'd0);
        vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL mid_reset got=%h exp=%h", got, exp); end
        reset = 1'b0; stall_F = 1'b0; flush_D = 1'b0; PCSrc_D = 1'b0; PCBranch_D = 64'h0;
        tick();
        got = pack(valid_D, pc_D, instr_D, fetch_count, imem_addr);
        exp = pack(1'b1, 64'h0, word(0), 32'd1, 6'd1);
        vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL mid_reset_resume got=%h exp=%h", got, exp); end
    endtask

    task automatic test_back_to_back();
        for (int k = 2; k < 6; k++) begin
            tick();
            got = pack(valid_D, pc_D, instr_D, fetch_count, imem_addr);
            exp = pack(1'b1, 64'(4 * (k - 1)), word(k - 1), 32'(k), 6'(k));
            vectors++;
            if (got !== exp) begin miscompares++; $display("FAIL back_to_back[%0d] got=%h exp=%h", k, got, exp); end
        end
    endtask

    task automatic test_pc_wrap();
        reset2 = 1'b0;
        tick();
        got = pack(valid_D2, pc_D2, instr_D2, fetch_count2, imem_addr2);
        exp = pack(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, word(63), 32'd1, 6'd0);
        vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL pc_wrap got=%h exp=%h", got, exp); end
        tick();
        got = pack(valid_D2, pc_D2, instr_D2, fetch_count2, imem_addr2);
        exp = pack(1'b1, 64'h0, word(0), 32'd2, 6'd1);
        vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL pc_wrap_next got=%h exp=%h", got, exp); end
    endtask

    initial begin
        reset = 1'b1; reset2 = 1'b1;
        stall_F = 1'b0; flush_D = 1'b0; PCSrc_D = 1'b0; PCBranch_D = 64'h0;
        test_reset();
        test_free_run();
        test_redirect();
        test_stall();
        test_stall_flush();
        test_redirect_over_stall();
        test_mid_reset();
        test_back_to_back();
        test_pc_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
